text_line_sequencer: RTL and testbench
======================================

Name: text_line_sequencer

Overview:
- Sequences the per-scanline glyph fetch for the text overlay.
- On each line-start request, walks the character string slot by slot: issues the character code and glyph row to the shared font ROM, waits the ROM latency, then writes the returned 10-bit row into the matching line-buffer slot.
- Holds a writable string register file. Takes a consistent per-line snapshot of it.
- Sits between the VGA timing controller (row number, line start) and the font ROM / line buffer datapath.

Parameters:
- NUM_CHARS, 6, number of character slots per line.
- SLOT_W, 3, slot index width; must satisfy 2**SLOT_W >= NUM_CHARS.
- GLYPH_ROWS, 16, glyph height in scanlines (row index 4 bits).
- ROM_LAT, 1, font ROM read latency in clocks; legal range 1..3.
- TEXT_Y0, 0, first scanline of the text window.
- INIT_STRING, 48'h48454C4C4F57, reset contents of the string, slot 0 in the MSBs.

Ports:
- CLOCK_50  in  1  system clock.
- RESET  in  1  synchronous, active-low reset.
- LINE_START  in  1  single-cycle request to prepare the line given by ROW_NUM.
- ROW_NUM  in  10  scanline to prepare; sampled with LINE_START.
- STR_WE  in  1  string write strobe.
- STR_ADDR  in  SLOT_W  string slot to write.
- STR_DATA  in  8  ASCII code to write.
- CHAR_CODE  out  8  character code to font ROM.
- GLYPH_ROW  out  4  glyph row index to font ROM.
- ROM_REQ  out  1  font ROM read strobe.
- FONT_DATA  in  10  ROM row data; valid ROM_LAT cycles after ROM_REQ.
- LB_WE  out  1  line-buffer slot write strobe.
- LB_SLOT  out  SLOT_W  line-buffer slot index.
- LB_DATA  out  10  line-buffer slot data.
- BUSY  out  1  high from the first FETCH through the last LB_WE.
- LINE_READY  out  1  one-cycle pulse when the line is complete.
- OVERRUN  out  1  sticky error flag.

Behaviour:
- Reset (RESET=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0; OVERRUN is cleared.
  - String register file reloads INIT_STRING.
  - The reset takes effect on the same edge even mid-line. No partial write completes after reset.
- FSM states:
  - IDLE -> FETCH on LINE_START.
  - FETCH -> WAIT if ROM_LAT>1; otherwise FETCH -> WRITE.
  - WAIT counts ROM_LAT-1 cycles, then -> WRITE.
  - WRITE -> FETCH while slots remain, else -> DONE.
  - DONE -> IDLE.
- Accepting LINE_START in IDLE at cycle t captures:
  - the string snapshot;
  - row offset = ROW_NUM - TEXT_Y0;
  - in_window = (TEXT_Y0 <= ROW_NUM < TEXT_Y0 + GLYPH_ROWS).
- Per-slot timing:
  - Slot i FETCH cycle: c_i = t+1+i*(ROM_LAT+1).
  - In the FETCH cycle, ROM_REQ=1, CHAR_CODE=snap[i], and GLYPH_ROW=offset[3:0].
  - FONT_DATA is sampled at c_i+ROM_LAT.
  - LB_WE=1, LB_SLOT=i, and LB_DATA=sample are registered and visible at c_i+ROM_LAT+1, for one cycle.
- Defaults: 6 slots, ROM_LAT=1. Last LB_WE at t+13, LINE_READY at t+14, BUSY high t+1..t+13.
- Outside the window:
  - ROM_REQ stays 0.
  - LB_WE writes still occur at identical times, with LB_DATA=0, so the line is cleared.
- CHAR_CODE and GLYPH_ROW hold their last value when ROM_REQ=0.
- String writes:
  - Accepted in any state and take effect on the next edge.
  - STR_ADDR >= NUM_CHARS is ignored.
  - STR_WE in the same cycle as an accepted LINE_START: the snapshot gets the old value; the new value appears on the next line.
- LINE_START while not in IDLE (including DONE): the request is ignored, OVERRUN is set and held until reset, and the current line completes normally.
- GLYPH_ROW arithmetic is 10-bit unsigned subtraction truncated to 4 bits; it is meaningful only when in_window.

Optional Feature:
- TEXT_CURSOR_EN defined:
  - Adds input CURSOR_SLOT (SLOT_W bits).
  - For the slot equal to CURSOR_SLOT, when in_window and offset is GLYPH_ROWS-2 or GLYPH_ROWS-1, LB_DATA is forced to 10'h3FF (underline cursor). The ROM is still read.
  - CURSOR_SLOT >= NUM_CHARS means no cursor.
- TEXT_CURSOR_EN undefined: the port is absent and LB_DATA is always the ROM data or 0.

Decomposition:
- Shared package text_pkg holds:
  - FSM state enum (IDLE, FETCH, WAIT, WRITE, DONE);
  - GLYPH_W=10, CHAR_W=8, GLYPH_ROWS default;
  - the default string constant.
- One sub-module, string_regfile: NUM_CHARS x 8 registers with write port, reset init and snapshot-load output.

Test Plan:
- Reset, then LINE_START with ROW_NUM=3 at t -> ROM_REQ at t+1,3,5,7,9,11 with CHAR_CODE 48,45,4C,4C,4F,57 and GLYPH_ROW=3; LB_WE at t+3..t+13 on odd offsets for slots 0..5; LINE_READY at t+14.
- ROW_NUM=20 with TEXT_Y0=0 -> no ROM_REQ; six LB_WE writes of 0 at the same cycles; LINE_READY at t+14.
- ROM_LAT=2 -> slot spacing of 3 cycles; LB_DATA equals FONT_DATA from 2 cycles after each ROM_REQ; LINE_READY at t+20.
- STR_WE addr 1 data 8'h41 in the same cycle as LINE_START -> this line fetches 45 for slot 1; the next line fetches 41. Address 6 write is ignored.
- Second LINE_START at t+5 -> OVERRUN=1 and stays 1; the first line completes unchanged. RESET=0 at t+6 -> all outputs 0 next cycle, no further LB_WE, and string restored.
- TEXT_CURSOR_EN, CURSOR_SLOT=2, ROW_NUM=14 -> slot 2 LB_DATA=3FF; other slots carry ROM data.

Source files
------------

// File: rtl/text_pkg.sv
// Shared types and constants for the text overlay line sequencer.
package text_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;

  localparam int GLYPH_W        = 10;
  localparam int CHAR_W         = 8;
  localparam int GLYPH_ROWS_DEF = 16;

  // Slot 0 lives in the most significant byte.
  localparam logic [47:0] DEFAULT_STRING = 48'h48454C4C4F57;

endpackage

// File: rtl/string_regfile.sv
// Writable per-slot character store with reset image and a per-line snapshot copy.
module string_regfile
  import text_pkg::*;
#(
  parameter int NUM_CHARS = 6,
  parameter int SLOT_W    = 3,
  parameter logic [NUM_CHARS*CHAR_W-1:0] INIT_STRING = DEFAULT_STRING
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET,
  input  logic                        we,
  input  logic [SLOT_W-1:0]           addr,
  input  logic [CHAR_W-1:0]           data,
  input  logic                        snap_ld,
  output logic [NUM_CHARS*CHAR_W-1:0] str_q,
  output logic [NUM_CHARS*CHAR_W-1:0] snap_q
);

  // Out-of-range addresses match no slot and are dropped.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      str_q <= INIT_STRING;
    end else begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        if (we && (addr == SLOT_W'(i)))
          str_q[CHAR_W*(NUM_CHARS-1-i) +: CHAR_W] <= data;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (snap_ld)
      snap_q <= str_q;
  end

endmodule

// File: rtl/text_line_sequencer.sv
// Per-scanline glyph fetch sequencer: font ROM reads into line-buffer slot writes.
// Optional underline cursor enabled by defining TEXT_CURSOR_EN (adds CURSOR_SLOT).
module text_line_sequencer
  import text_pkg::*;
#(
  parameter int NUM_CHARS  = 6,
  parameter int SLOT_W     = 3,
  parameter int GLYPH_ROWS = GLYPH_ROWS_DEF,
  parameter int ROM_LAT    = 1,
  parameter int TEXT_Y0    = 0,
  parameter logic [NUM_CHARS*CHAR_W-1:0] INIT_STRING = DEFAULT_STRING
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               LINE_START,
  input  logic [9:0]         ROW_NUM,
  input  logic               STR_WE,
  input  logic [SLOT_W-1:0]  STR_ADDR,
  input  logic [CHAR_W-1:0]  STR_DATA,
`ifdef TEXT_CURSOR_EN
  input  logic [SLOT_W-1:0]  CURSOR_SLOT,
`endif
  output logic [CHAR_W-1:0]  CHAR_CODE,
  output logic [3:0]         GLYPH_ROW,
  output logic               ROM_REQ,
  input  logic [GLYPH_W-1:0] FONT_DATA,
  output logic               LB_WE,
  output logic [SLOT_W-1:0]  LB_SLOT,
  output logic [GLYPH_W-1:0] LB_DATA,
  output logic               BUSY,
  output logic               LINE_READY,
  output logic               OVERRUN
);

  state_t                        state;
  logic [SLOT_W-1:0]             slot;
  logic [1:0]                    wait_cnt;
  logic [3:0]                    offset_q;
  logic                          in_win_q;
  logic [NUM_CHARS*CHAR_W-1:0]   str_q;
  logic [NUM_CHARS*CHAR_W-1:0]   snap_q;
  logic                          accept;
  logic [10:0]                   row_ext;
  logic                          row_in_win;
  logic [3:0]                    row_off;
  logic [GLYPH_W-1:0]            wr_data;

  function automatic logic [CHAR_W-1:0] char_at(input logic [NUM_CHARS*CHAR_W-1:0] v,
                                                input logic [SLOT_W-1:0] idx);
    char_at = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (idx == SLOT_W'(i))
        char_at = v[CHAR_W*(NUM_CHARS-1-i) +: CHAR_W];
    end
  endfunction

  assign accept     = LINE_START && (state == IDLE);
  assign row_ext    = {1'b0, ROW_NUM};
  assign row_in_win = (row_ext >= 11'(TEXT_Y0)) && (row_ext < 11'(TEXT_Y0 + GLYPH_ROWS));
  assign row_off    = ROW_NUM[3:0] - 4'(TEXT_Y0);

  string_regfile #(
    .NUM_CHARS   (NUM_CHARS),
    .SLOT_W      (SLOT_W),
    .INIT_STRING (INIT_STRING)
  ) u_str (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .we       (STR_WE),
    .addr     (STR_ADDR),
    .data     (STR_DATA),
    .snap_ld  (accept),
    .str_q    (str_q),
    .snap_q   (snap_q)
  );

  // Out-of-window lines still write every slot, with zeros, to clear the buffer.
  always_comb begin
    wr_data = in_win_q ? FONT_DATA : '0;
`ifdef TEXT_CURSOR_EN
    if (in_win_q && (CURSOR_SLOT == slot) &&
        ((offset_q == 4'(GLYPH_ROWS-2)) || (offset_q == 4'(GLYPH_ROWS-1))))
      wr_data = '1;
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      state      <= IDLE;
      slot       <= '0;
      wait_cnt   <= '0;
      offset_q   <= '0;
      in_win_q   <= 1'b0;
      CHAR_CODE  <= '0;
      GLYPH_ROW  <= '0;
      ROM_REQ    <= 1'b0;
      LB_WE      <= 1'b0;
      LB_SLOT    <= '0;
      LB_DATA    <= '0;
      BUSY       <= 1'b0;
      LINE_READY <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      ROM_REQ    <= 1'b0;
      LB_WE      <= 1'b0;
      LINE_READY <= 1'b0;
      if (LINE_START && (state != IDLE))
        OVERRUN <= 1'b1;

      case (state)
        IDLE: begin
          if (LINE_START) begin
            state    <= FETCH;
            slot     <= '0;
            BUSY     <= 1'b1;
            in_win_q <= row_in_win;
            offset_q <= row_off;
            // Slot 0 is issued on the accept edge, before the snapshot is readable.
            if (row_in_win) begin
              ROM_REQ   <= 1'b1;
              CHAR_CODE <= char_at(str_q, '0);
              GLYPH_ROW <= row_off;
            end
          end
        end
        FETCH: begin
          if (ROM_LAT > 1) begin
            state    <= WAIT;
            wait_cnt <= 2'(ROM_LAT - 2);
          end else begin
            state <= WRITE;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0)
            state <= WRITE;
          else
            wait_cnt <= wait_cnt - 2'd1;
        end
        WRITE: begin
          LB_WE   <= 1'b1;
          LB_SLOT <= slot;
          LB_DATA <= wr_data;
          if (slot == SLOT_W'(NUM_CHARS - 1)) begin
            state <= DONE;
          end else begin
            state <= FETCH;
            slot  <= slot + 1'b1;
            if (in_win_q) begin
              ROM_REQ   <= 1'b1;
              CHAR_CODE <= char_at(snap_q, slot + 1'b1);
              GLYPH_ROW <= offset_q;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          BUSY       <= 1'b0;
          LINE_READY <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_line_sequencer.sv
// Scoreboard bench for text_line_sequencer: ROM_LAT=1 and ROM_LAT=2 instances share stimulus.
module tb_text_line_sequencer;
  import text_pkg::*;

  localparam int NC = 6;
  localparam int SW = 3;

  typedef struct {
    int cyc;
    int a;
    int b;
  } ev_t;

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic           RESET, LINE_START, STR_WE;
  logic [9:0]     ROW_NUM;
  logic [SW-1:0]  STR_ADDR;
  logic [7:0]     STR_DATA;
  logic [SW-1:0]  cursor;

  logic [7:0]     cc   [2];
  logic [3:0]     gr   [2];
  logic           req  [2];
  logic           we   [2];
  logic [SW-1:0]  sl   [2];
  logic [9:0]     lbd  [2];
  logic           busy [2];
  logic           rdy  [2];
  logic           ovr  [2];
  logic [9:0]     fd   [2];

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  ev_t  q [2][3][$];
  logic [7:0] str_m [NC];

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  text_line_sequencer #(.ROM_LAT(1)) u_dut1 (
    .CLOCK_50 (CLOCK_50), .RESET (RESET), .LINE_START (LINE_START), .ROW_NUM (ROW_NUM),
    .STR_WE (STR_WE), .STR_ADDR (STR_ADDR), .STR_DATA (STR_DATA),
`ifdef TEXT_CURSOR_EN
    .CURSOR_SLOT (cursor),
`endif
    .CHAR_CODE (cc[0]), .GLYPH_ROW (gr[0]), .ROM_REQ (req[0]), .FONT_DATA (fd[0]),
    .LB_WE (we[0]), .LB_SLOT (sl[0]), .LB_DATA (lbd[0]), .BUSY (busy[0]),
    .LINE_READY (rdy[0]), .OVERRUN (ovr[0])
  );

  text_line_sequencer #(.ROM_LAT(2)) u_dut2 (
    .CLOCK_50 (CLOCK_50), .RESET (RESET), .LINE_START (LINE_START), .ROW_NUM (ROW_NUM),
    .STR_WE (STR_WE), .STR_ADDR (STR_ADDR), .STR_DATA (STR_DATA),
`ifdef TEXT_CURSOR_EN
    .CURSOR_SLOT (cursor),
`endif
    .CHAR_CODE (cc[1]), .GLYPH_ROW (gr[1]), .ROM_REQ (req[1]), .FONT_DATA (fd[1]),
    .LB_WE (we[1]), .LB_SLOT (sl[1]), .LB_DATA (lbd[1]), .BUSY (busy[1]),
    .LINE_READY (rdy[1]), .OVERRUN (ovr[1])
  );

  function automatic logic [9:0] font_fn(input logic [7:0] c, input logic [3:0] r);
    return {c, 2'b01} ^ {r, 6'b000000};
  endfunction

  // Font ROM models; off-time data is a marker so mistimed sampling shows up.
  logic       v1, v2a, v2b;
  logic [9:0] d1, d2a, d2b;
  always @(posedge CLOCK_50) begin
    v1  <= req[0];
    d1  <= font_fn(cc[0], gr[0]);
    v2a <= req[1];
    d2a <= font_fn(cc[1], gr[1]);
    v2b <= v2a;
    d2b <= d2a;
  end
  assign fd[0] = (v1 === 1'b1) ? d1 : 10'h2AA;
  assign fd[1] = (v2b === 1'b1) ? d2b : 10'h2AA;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input int d, input string what);
    tests++;
    fails++;
    $display("FAIL dut%0d %s: got an event at cycle %0d, expected none", d, what, cyc);
  endtask

  task automatic mon(input int d, input logic rq, input logic [7:0] c, input logic [3:0] g,
                     input logic w, input logic [SW-1:0] s, input logic [9:0] dat,
                     input logic r);
    ev_t e;
    if (rq === 1'b1) begin
      if (q[d][0].size() == 0) unexpected(d, "ROM_REQ");
      else begin
        e = q[d][0].pop_front();
        chk($sformatf("dut%0d rom cycle", d), cyc, e.cyc);
        chk($sformatf("dut%0d CHAR_CODE", d), 32'(c), e.a);
        chk($sformatf("dut%0d GLYPH_ROW", d), 32'(g), e.b);
      end
    end
    if (w === 1'b1) begin
      if (q[d][1].size() == 0) unexpected(d, "LB_WE");
      else begin
        e = q[d][1].pop_front();
        chk($sformatf("dut%0d lb cycle", d), cyc, e.cyc);
        chk($sformatf("dut%0d LB_SLOT", d), 32'(s), e.a);
        chk($sformatf("dut%0d LB_DATA", d), 32'(dat), e.b);
      end
    end
    if (r === 1'b1) begin
      if (q[d][2].size() == 0) unexpected(d, "LINE_READY");
      else begin
        e = q[d][2].pop_front();
        chk($sformatf("dut%0d ready cycle", d), cyc, e.cyc);
      end
    end
  endtask

  always @(negedge CLOCK_50) begin
    mon(0, req[0], cc[0], gr[0], we[0], sl[0], lbd[0], rdy[0]);
    mon(1, req[1], cc[1], gr[1], we[1], sl[1], lbd[1], rdy[1]);
  end

  task automatic reset_str();
    str_m = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h57};
  endtask

  task automatic push_line(input int d, input int t, input int row);
    int lat, c;
    bit inw;
    logic [3:0] off;
    ev_t e;
    lat = (d == 0) ? 1 : 2;
    inw = (row < 16);
    off = 4'(row);
    for (int i = 0; i < NC; i++) begin
      c = t + 1 + i * (lat + 1);
      if (inw) begin
        e.cyc = c; e.a = int'(str_m[i]); e.b = int'(off);
        q[d][0].push_back(e);
      end
      e.cyc = c + lat + 1;
      e.a   = i;
      e.b   = inw ? int'(font_fn(str_m[i], off)) : 0;
`ifdef TEXT_CURSOR_EN
      if (inw && (int'(cursor) == i) && (off >= 4'd14)) e.b = 'h3FF;
`endif
      q[d][1].push_back(e);
    end
    e.cyc = t + NC * (lat + 1) + 2; e.a = 0; e.b = 0;
    q[d][2].push_back(e);
  endtask

  task automatic issue_line(input int row, input logic w, input logic [SW-1:0] a,
                            input logic [7:0] dv, output int t);
    @(posedge CLOCK_50); #1;
    LINE_START = 1'b1; ROW_NUM = 10'(row);
    STR_WE = w; STR_ADDR = a; STR_DATA = dv;
    t = cyc;
    push_line(0, t, row);
    push_line(1, t, row);
    if (w && (int'(a) < NC)) str_m[a] = dv;
    @(posedge CLOCK_50); #1;
    LINE_START = 1'b0; STR_WE = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge CLOCK_50);
  endtask

  task automatic flush_after(input int lim);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++)
        for (int i = q[d][k].size() - 1; i >= 0; i--)
          if (q[d][k][i].cyc > lim) q[d][k].delete(i);
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s dut%0d ROM_REQ", tag, d), 32'(req[d]), 0);
      chk($sformatf("%s dut%0d LB_WE", tag, d), 32'(we[d]), 0);
      chk($sformatf("%s dut%0d BUSY", tag, d), 32'(busy[d]), 0);
      chk($sformatf("%s dut%0d LINE_READY", tag, d), 32'(rdy[d]), 0);
      chk($sformatf("%s dut%0d OVERRUN", tag, d), 32'(ovr[d]), 0);
      chk($sformatf("%s dut%0d CHAR_CODE", tag, d), 32'(cc[d]), 0);
      chk($sformatf("%s dut%0d LB_DATA", tag, d), 32'(lbd[d]), 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    RESET = 1'b0; LINE_START = 1'b0; STR_WE = 1'b0;
    ROW_NUM = '0; STR_ADDR = '0; STR_DATA = '0; cursor = 3'd7;
    reset_str();
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk_zero("reset");
    RESET = 1'b1;

    // In-window line at row 3
    issue_line(3, 1'b0, '0, '0, t);
    wait_cyc(t + 1);
    chk("busy1 start", 32'(busy[0]), 1);
    chk("busy2 start", 32'(busy[1]), 1);
    wait_cyc(t + 13);
    chk("busy1 last write", 32'(busy[0]), 1);
    wait_cyc(t + 14);
    chk("busy1 end", 32'(busy[0]), 0);
    wait_cyc(t + 19);
    chk("busy2 last write", 32'(busy[1]), 1);
    wait_cyc(t + 20);
    chk("busy2 end", 32'(busy[1]), 0);
    wait_cyc(t + 24);

    // Out-of-window line clears slots; ROM address outputs hold
    issue_line(20, 1'b0, '0, '0, t);
    wait_cyc(t + 3);
    chk("hold CHAR_CODE", 32'(cc[0]), 32'h57);
    chk("hold GLYPH_ROW", 32'(gr[0]), 3);
    wait_cyc(t + 24);

    // Write coincident with accept lands on the following line
    issue_line(5, 1'b1, 3'd1, 8'h41, t);
    wait_cyc(t + 24);
    @(posedge CLOCK_50); #1;
    STR_WE = 1'b1; STR_ADDR = 3'd6; STR_DATA = 8'h5A;
    @(posedge CLOCK_50); #1;
    STR_WE = 1'b0;
    issue_line(7, 1'b0, '0, '0, t);
    wait_cyc(t + 24);

`ifdef TEXT_CURSOR_EN
    cursor = 3'd2;
    issue_line(14, 1'b0, '0, '0, t);
    wait_cyc(t + 24);
    cursor = 3'd7;
`endif

    // Overrun: request while busy is ignored, flag is sticky
    issue_line(2, 1'b0, '0, '0, t);
    wait_cyc(t + 5);
    LINE_START = 1'b1; ROW_NUM = 10'd9;
    @(posedge CLOCK_50); #1;
    LINE_START = 1'b0;
    wait_cyc(t + 6);
    chk("overrun1 set", 32'(ovr[0]), 1);
    chk("overrun2 set", 32'(ovr[1]), 1);
    wait_cyc(t + 24);
    chk("overrun1 sticky", 32'(ovr[0]), 1);
    chk("overrun2 sticky", 32'(ovr[1]), 1);

    // Reset mid-line aborts the line and restores the string
    issue_line(6, 1'b0, '0, '0, t);
    wait_cyc(t + 6);
    RESET = 1'b0;
    flush_after(t + 6);
    reset_str();
    @(posedge CLOCK_50); #1;
    RESET = 1'b1;
    wait_cyc(t + 7);
    chk_zero("midline reset");
    wait_cyc(t + 24);
    issue_line(4, 1'b0, '0, '0, t);
    wait_cyc(t + 24);

    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++)
        while (q[d][k].size() > 0) begin
          ev_t e;
          e = q[d][k].pop_front();
          tests++;
          fails++;
          $display("FAIL dut%0d missing event kind %0d: got nothing, expected at cycle %0d", d, k, e.cyc);
        end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
